// File: rtl/pmem_line_responder.sv
// pmem_line_responder: 256-bit line memory, one read/write at a time,
// LATENCY wait cycles, then four 64-bit beats, then a one-cycle resp.
// Ports: clk, rst_n, read, write, address, wdata -> resp, rdata.
// Optional: PMEM_PROTO_CHECK_EN adds the sticky proto_err output.
module pmem_line_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [255:0] wdata,
  output logic         resp,
  output logic [255:0] rdata
`ifdef PMEM_PROTO_CHECK_EN
  ,
  output logic         proto_err
`endif
);

  localparam int IW = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE, WAIT, BEAT, RESP
  } state_t;

  state_t state, state_nx;

  logic [7:0]    wait_cnt;
  logic [1:0]    beat_cnt;
  logic          op_wr;
  logic [IW-1:0] idx;
  logic [255:0]  wline;
  logic [255:0]  rline;
  logic          accept;
  logic [IW+1:0] waddr;
  logic [7:0]    boff;

  logic [63:0] mem [LINES*4];

  assign accept = (state == IDLE) && (read || write);
  assign waddr  = {idx, beat_cnt};
  assign boff   = {beat_cnt, 6'd0};
  assign resp   = (state == RESP);
  assign rdata  = rline;

  // Only the index bits select a line; the rest alias.
  logic unused_addr;
  assign unused_addr = ^{address[4:0], address[31:5+IW]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = (LATENCY == 0) ? BEAT : WAIT;
      WAIT: if (wait_cnt <= 8'd1)
              state_nx = BEAT;
      BEAT: if (beat_cnt == 2'd3)
              state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wline    <= '0;
      rline    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_wr    <= write;
        idx      <= address[5 +: IW];
        wline    <= wdata;
        wait_cnt <= LATENCY[7:0];
        beat_cnt <= '0;
      end
      if (state == WAIT && wait_cnt != 8'd0)
        wait_cnt <= wait_cnt - 8'd1;
      if (state == BEAT) begin
        beat_cnt <= beat_cnt + 2'd1;
        if (!op_wr)
          rline[boff +: 64] <= mem[waddr];
      end
    end
  end

  // Array is deliberately not reset; a reset mid-write leaves
  // already-completed beats in place because state drops to IDLE.
  always_ff @(posedge clk) begin
    if (state == BEAT && op_wr)
      mem[waddr] <= wline[boff +: 64];
  end

`ifdef PMEM_PROTO_CHECK_EN
  logic        lat_rd;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic        chg;

  assign chg = (read != lat_rd) || (write != lat_wr) ||
               (address != lat_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        lat_rd   <= read;
        lat_wr   <= write;
        lat_addr <= address;
        if (read && write)
          proto_err <= 1'b1;
      end
      // A dropped request shows up here as a change too.
      if (state != IDLE && chg)
        proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: directed + random checks of the line
// responder against a line-level reference model (two configs).
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd, wr, sel;
  logic [31:0]  address;
  logic [255:0] wdata;
  logic         read_a, write_a, read_b, write_b;
  logic         resp_a, resp_b;
  logic [255:0] rdata_a, rdata_b;
`ifdef PMEM_PROTO_CHECK_EN
  logic         perr_a, perr_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [255:0] mdl_a [256];
  logic [255:0] mdl_b [4];
  logic [255:0] exp_rd_a, exp_rd_b;

  always #5 clk = ~clk;

  assign read_a  = rd & ~sel;
  assign write_a = wr & ~sel;
  assign read_b  = rd & sel;
  assign write_b = wr & sel;

  pmem_line_responder #(.LINES(256), .LATENCY(10)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .read    (read_a),
    .write   (write_a),
    .address (address),
    .wdata   (wdata),
    .resp    (resp_a),
    .rdata   (rdata_a)
`ifdef PMEM_PROTO_CHECK_EN
    ,
    .proto_err (perr_a)
`endif
  );

  pmem_line_responder #(.LINES(4), .LATENCY(0)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .read    (read_b),
    .write   (write_b),
    .address (address),
    .wdata   (wdata),
    .resp    (resp_b),
    .rdata   (rdata_b)
`ifdef PMEM_PROTO_CHECK_EN
    ,
    .proto_err (perr_b)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input bit s, input logic [31:0] a);
    return int'((a >> 5) % (s ? 32'd4 : 32'd256));
  endfunction

  // One transaction on the selected DUT; the request is left held so
  // the next call lands in the IDLE cycle right after resp.
  task automatic op(input bit s, input bit r, input bit w,
                    input logic [31:0] a, input logic [255:0] d,
                    input bit glitch);
    int n;
    bit got;
    int ix;
    @(negedge clk);
    check("resp_gap", s ? resp_b : resp_a, '0);
    sel = s; rd = r; wr = w; address = a; wdata = d;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (glitch && n == 2) address = a ^ 32'h0000_0020;
      if (s ? resp_b : resp_a) got = 1;
    end
    check(s ? "latency_b" : "latency_a", n, s ? 5 : 15);
    ix = idx_of(s, a);
    if (s) begin
      if (w) mdl_b[ix] = d;
      else   exp_rd_b = mdl_b[ix];
    end else begin
      if (w) mdl_a[ix] = d;
      else   exp_rd_a = mdl_a[ix];
    end
    check(s ? "rdata_b" : "rdata_a", s ? rdata_b : rdata_a,
          s ? exp_rd_b : exp_rd_a);
  endtask

  task automatic idle();
    @(negedge clk);
    rd = 0; wr = 0;
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [31:0] a;
    logic [255:0] d;
    int ix, kind;

    rst_n = 0; rd = 0; wr = 0; sel = 0;
    address = '0; wdata = '0;
    exp_rd_a = '0; exp_rd_b = '0;
    repeat (2) @(negedge clk);
    check("rst_resp", resp_a, '0);
    check("rst_rdata_a", rdata_a, '0);
    check("rst_rdata_b", rdata_b, '0);
`ifdef PMEM_PROTO_CHECK_EN
    check("rst_perr", perr_a, '0);
`endif
    rst_n = 1;

    // Write then read back, back-to-back.
    op(0, 0, 1, 32'h0000_0040,
       {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
    op(0, 1, 0, 32'h0000_0040, '0, 0);
    // Aliasing: 0x2020 and 0x20 are both index 1.
    op(0, 0, 1, 32'h0000_2020, {32{8'hA5}}, 0);
    op(0, 1, 0, 32'h0000_0020, '0, 0);
    idle();
`ifdef PMEM_PROTO_CHECK_EN
    check("perr_legal", perr_a, '0);
`endif

    // Reset during beat 2 of a write to line 3.
    op(0, 0, 1, 32'h0000_0060, '0, 0);
    @(negedge clk);
    sel = 0; rd = 0; wr = 1; address = 32'h0000_0060; wdata = '1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst_n = 0; wr = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1;
      if (resp_a) seen = 1;
    end
    check("rst_mid_resp", seen, '0);
    check("rst_mid_rdata", rdata_a, '0);
    mdl_a[3] = {128'd0, {128{1'b1}}};
    exp_rd_a = '0; exp_rd_b = '0;
    op(0, 1, 0, 32'h0000_0060, '0, 0);
    idle();

    // LATENCY=0, LINES=4 instance; 0xA0 aliases to index 1.
    d = rnd_line();
    op(1, 0, 1, 32'h0000_0020, d, 0);
    op(1, 1, 0, 32'h0000_0020, '0, 0);
    op(1, 1, 0, 32'h0000_00A0, '0, 0);
    idle();

`ifdef PMEM_PROTO_CHECK_EN
    op(0, 1, 0, 32'h0000_0040, '0, 1);
    idle();
    check("perr_glitch", perr_a, 1);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    exp_rd_a = '0; exp_rd_b = '0;
    check("perr_clear", perr_a, '0);
    op(0, 1, 1, 32'h0000_0080, '1, 0);
    idle();
    check("perr_rw", perr_a, 1);
    op(0, 1, 0, 32'h0000_0080, '0, 0);
    idle();
    check("perr_sticky", perr_a, 1);
`endif

    // Random traffic on lines 0..7 with random aliasing bits.
    for (int i = 0; i < 8; i++) begin
      a = ($urandom & 32'hFFFF_E01F) | (32'(i) << 5);
      op(0, 0, 1, a, rnd_line(), 0);
    end
    for (int i = 0; i < 24; i++) begin
      ix = $urandom_range(0, 7);
      kind = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_E01F) | (32'(ix) << 5);
      op(0, kind != 1, kind != 0 && kind != 2, a, rnd_line(), 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
